// File: rtl/mul_issue_unit_pkg.sv
// Shared types for the multiplier issue unit: data word, multiplier op
// encoding, issue-buffer payload and in-flight tracker entry.
package mul_issue_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MUL_TAG_W = 6;

  typedef logic [XLEN-1:0] data_u;

  typedef enum logic [1:0] {
    MUL_    = 2'd0,
    MULH_   = 2'd1,
    MULHSU_ = 2'd2,
    MULHU_  = 2'd3
  } mul_ops_e;

  // One in-flight multiplier slot.
  typedef struct packed {
    logic                 valid;
    logic [MUL_TAG_W-1:0] tag;
  } mul_trk_entry_t;

  // One buffered op waiting for issue.
  typedef struct packed {
    data_u                a;
    data_u                b;
    mul_ops_e             op;
    logic [MUL_TAG_W-1:0] tag;
  } mul_issue_entry_t;

endpackage

// File: rtl/mul_issue_fifo.sv
// Two-entry in-order issue buffer for the multiplier issue unit.
// Ports:
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   flush_i         drop all entries (beats push/pop)
//   push_i, wdata_i write one entry (ignored when full)
//   pop_i           retire the head entry (ignored when empty)
//   head_o          current head entry
//   count_o         number of valid entries (0..2)
module mul_issue_fifo
  import mul_issue_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  mul_issue_entry_t wdata_i,
  input  logic             pop_i,
  output mul_issue_entry_t head_o,
  output logic [1:0]       count_o
);

  mul_issue_entry_t mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push_c;
  logic             do_pop_c;

  assign do_push_c = push_i && (count_q != 2'd2);
  assign do_pop_c  = pop_i  && (count_q != 2'd0);

  // Pointers and occupancy; reset beats flush beats push/pop.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop_c)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy qualifies it.
  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mul_issue_unit.sv
// Multiplier issue unit: accepts multiply ops, feeds an external pipelined
// multiplier and tracks in-flight ops so results leave in issue order with
// their tags. Build option MUL_ISSUE_BUFFER_EN adds a 2-entry issue buffer;
// without it operands pass straight through and issue happens on accept.
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   valid_i/ready_o                op handshake (multiplicand_i, multiplier_i,
//                                  ops_i, tag_i)
//   stall_i, flush_i               core stall, kill everything buffered/in flight
//   mul_a_o, mul_b_o, mul_ops_o    operands/op to the multiplier
//   mul_clk_en_o                   multiplier pipeline enable
//   mul_result_i                   multiplier result
//   result_valid_o/result_ready_i  result handshake (result_o, result_tag_o)
//   busy_o                         anything buffered or in flight
module mul_issue_unit
  import mul_issue_unit_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 5,
  parameter int unsigned TAG_W       = 6
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  data_u            multiplicand_i,
  input  data_u            multiplier_i,
  input  mul_ops_e         ops_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output data_u            mul_a_o,
  output data_u            mul_b_o,
  output mul_ops_e         mul_ops_o,
  output logic             mul_clk_en_o,
  input  data_u            mul_result_i,
  output logic             result_valid_o,
  output data_u            result_o,
  output logic [TAG_W-1:0] result_tag_o,
  input  logic             result_ready_i,
  output logic             busy_o
);

  mul_trk_entry_t       trk_q [MUL_LATENCY];
  logic                 issue_c;
  logic [MUL_TAG_W-1:0] issue_tag_c;
  logic                 buf_busy_c;
  logic                 trk_busy_c;

  // Results come straight from the last tracker slot and the multiplier;
  // masked while reset is asserted so nothing leaks out mid-reset.
  assign result_valid_o = rst_n_i && trk_q[MUL_LATENCY-1].valid;
  assign result_tag_o   = TAG_W'(trk_q[MUL_LATENCY-1].tag);
  assign result_o       = mul_result_i;

  // A held result freezes the multiplier and tracker together.
  assign mul_clk_en_o = !stall_i && (!result_valid_o || result_ready_i);

`ifdef MUL_ISSUE_BUFFER_EN
  mul_issue_entry_t wdata_c;
  mul_issue_entry_t head_c;
  logic [1:0]       count_c;
  logic             buf_nonempty_c;

  assign wdata_c = '{a: multiplicand_i, b: multiplier_i, op: ops_i,
                     tag: MUL_TAG_W'(tag_i)};
  assign buf_nonempty_c = (count_c != 2'd0);

  // Buffer reset wins over the handshake, so advertising ready in reset is safe.
  assign ready_o    = !rst_n_i || (count_c < 2'd2);
  assign issue_c    = mul_clk_en_o && buf_nonempty_c;
  assign buf_busy_c = buf_nonempty_c;

  // Only the head is ever presented, so an op pushed into an empty buffer
  // issues no earlier than the following enabled edge.
  assign mul_a_o     = buf_nonempty_c ? head_c.a  : '0;
  assign mul_b_o     = buf_nonempty_c ? head_c.b  : '0;
  assign mul_ops_o   = buf_nonempty_c ? head_c.op : MUL_;
  assign issue_tag_c = head_c.tag;

  mul_issue_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .push_i  (valid_i && ready_o),
    .wdata_i (wdata_c),
    .pop_i   (issue_c),
    .head_o  (head_c),
    .count_o (count_c)
  );
`else
  // No buffering: accept only when the multiplier advances this edge.
  assign ready_o     = mul_clk_en_o;
  assign issue_c     = valid_i && mul_clk_en_o;
  assign buf_busy_c  = 1'b0;
  assign mul_a_o     = multiplicand_i;
  assign mul_b_o     = multiplier_i;
  assign mul_ops_o   = ops_i;
  assign issue_tag_c = MUL_TAG_W'(tag_i);
`endif

  // In-flight tracker, mirrors the multiplier pipeline stage for stage.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      for (int unsigned i = 0; i < MUL_LATENCY; i++) trk_q[i] <= '0;
    end else if (mul_clk_en_o) begin
      trk_q[0] <= '{valid: issue_c, tag: issue_tag_c};
      for (int unsigned i = 1; i < MUL_LATENCY; i++) trk_q[i] <= trk_q[i-1];
    end
  end

  always_comb begin
    trk_busy_c = 1'b0;
    for (int unsigned i = 0; i < MUL_LATENCY; i++) trk_busy_c = trk_busy_c | trk_q[i].valid;
  end

  assign busy_o = rst_n_i && (buf_busy_c || trk_busy_c);

endmodule

// File: doc/mul_issue_unit.md
MUL_ISSUE_UNIT -- requirements
Module: mul_issue_unit

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 5: count of enabled clock edges from operand issue to a valid multiplier result.
REQ-002 SHALL have parameter TAG_W, default 6: width of the destination/ROB tag.
REQ-003 SHALL have one clock and a synchronous, active-low reset. The ports are listed below.
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- valid_i  in  1  upstream op valid
- ready_o  out  1  unit can accept an op
- multiplicand_i  in  data_u  operand A
- multiplier_i  in  data_u  operand B
- ops_i  in  mul_ops_e  MUL_/MULH_/MULHSU_/MULHU_
- tag_i  in  TAG_W  destination tag
- stall_i  in  1  core-wide stall
- flush_i  in  1  kill all buffered and in-flight ops
- mul_a_o  out  data_u  operand A to multiplier
- mul_b_o  out  data_u  operand B to multiplier
- mul_ops_o  out  mul_ops_e  op to multiplier
- mul_clk_en_o  out  1  multiplier pipeline enable
- mul_result_i  in  data_u  selected multiplier result
- result_valid_o  out  1  result available
- result_o  out  data_u  result data
- result_tag_o  out  TAG_W  tag of the result
- result_ready_i  in  1  writeback accepts the result
- busy_o  out  1  buffer non-empty or op in flight

Function
REQ-004 SHALL drive mul_clk_en_o = !stall_i && (!result_valid_o || result_ready_i). An edge with mul_clk_en_o high is an "enabled edge".
REQ-005 SHALL hold a 2-entry in-order issue buffer storing {A, B, op, tag}. The buffer pushes on valid_i && ready_o.
REQ-006 SHALL drive ready_o = (buffer count < 2). ready_o is registered-count based and is independent of valid_i.
REQ-007 SHALL, on each enabled edge with the buffer non-empty, present the head entry on mul_a_o/mul_b_o/mul_ops_o before the edge, pop it at the edge, and shift valid=1 plus its tag into the in-flight tracker.
REQ-008 SHALL, on an enabled edge with the buffer empty, shift valid=0 into the tracker. During such an edge mul_a_o/mul_b_o SHALL be zero.
REQ-009 SHALL implement the tracker as a MUL_LATENCY-deep {valid, tag} shift register that advances only on enabled edges.
REQ-010 SHALL drive result_valid_o = valid bit of the last tracker stage, result_tag_o = its tag, and result_o = mul_result_i, all combinationally.
REQ-011 SHALL, while result_valid_o && !result_ready_i, freeze the tracker and the multiplier through mul_clk_en_o, and hold result_valid_o, result_o and result_tag_o stable.
REQ-012 SHALL, while stall_i is high, freeze the tracker and block pops. Pushes into the buffer remain allowed while count < 2.
REQ-013 SHALL handle a push and a pop at the same edge: the count is unchanged and order is preserved. A push into an empty buffer SHALL NOT be issued at that same edge; it issues at the earliest next enabled edge.
REQ-014 SHALL, on flush_i, clear the buffer count and all tracker valid bits at the next edge. flush_i has priority over push and pop, and the push of that cycle is discarded.
REQ-015 SHALL drive busy_o = (count != 0) || (any tracker valid bit set).
REQ-016 SHALL guarantee results exit in issue order, each exactly once.

Reset
REQ-017 SHALL, on rst_n_i low at an edge, clear the buffer count, buffer pointers and tracker valid bits. Reset has priority over flush_i, stall_i and the handshakes.
REQ-018 SHALL, during and after reset, drive ready_o=1, result_valid_o=0, busy_o=0 and mul_clk_en_o per REQ-004. A reset asserted mid-operation discards every op.

Configuration
REQ-019 SHALL, with MUL_ISSUE_BUFFER_EN defined, implement REQ-005..REQ-008 and REQ-013 with the 2-entry buffer.
REQ-020 SHALL, without MUL_ISSUE_BUFFER_EN, omit the buffer and work as follows:
- mul_a_o/mul_b_o/mul_ops_o are passed through from the inputs.
- ready_o = mul_clk_en_o, combinationally.
- Issue occurs on valid_i && ready_o at an enabled edge.
- All other requirements still apply.

Structure
REQ-021 SHALL take XLEN, data_u and mul_ops_e from the shared packages. The tracker entry struct {valid, tag} SHALL be added to the shared modules package.
REQ-022 SHALL implement the buffer as a sub-module named mul_issue_fifo. Only this sub-module is removed when MUL_ISSUE_BUFFER_EN is undefined.

Verification
REQ-023 Single op: MUL_, A=7, B=-3, tag=5, no stall; multiplier model returns -21 after 5 enabled edges -> result_valid_o high once with result_o=-21, tag=5, in the 6th cycle after push.
REQ-024 Back-to-back: 4 ops with tags 1..4 pushed on consecutive cycles, result_ready_i=1 -> ready_o never drops after the first op; results arrive with tags 1,2,3,4 on consecutive cycles.
REQ-025 Backpressure: result_ready_i=0 for 3 cycles while the tag=1 result is valid -> outputs held, mul_clk_en_o=0, buffer fills to 2 and ready_o=0; results resume in order after release.
REQ-026 Stall: stall_i=1 for 4 cycles with 2 ops in flight -> tracker frozen, no result lost or duplicated, total latency extended by exactly 4.
REQ-027 Flush: flush_i in the cycle after 3 pushes -> no result_valid_o afterward, busy_o=0 and ready_o=1 next cycle.
REQ-028 Reset mid-flight: rst_n_i=0 for 1 cycle with 2 ops in flight -> no results emitted, outputs at their reset values.
